// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: PC-in mux select codes, sequencer states
// and redirect kinds, whose numeric order is their priority (higher wins).
package pipe_pkg;

  localparam logic [2:0] SEL_SEQ = 3'b000;
  localparam logic [2:0] SEL_BR  = 3'b001;
  localparam logic [2:0] SEL_J   = 3'b010;
  localparam logic [2:0] SEL_JR  = 3'b100;

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    RUN       = 2'd1,
    HOLD      = 2'd2,
    HOLD_PEND = 2'd3
  } seqState_t;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_J    = 2'd1,
    KIND_JR   = 2'd2,
    KIND_BR   = 2'd3
  } redirKind_t;

  function automatic logic [2:0] kindToSel(input redirKind_t kind);
    logic [2:0] sel;
    case (kind)
      KIND_BR: sel = SEL_BR;
      KIND_JR: sel = SEL_JR;
      KIND_J:  sel = SEL_J;
      default: sel = SEL_SEQ;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/redirect_prio.sv
// Combinational priority select over the latched redirect and the live requests.
// A live request displaces the pending one only when strictly higher priority.
module redirect_prio
  import pipe_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              liveEn,
  input  redirKind_t        pendKind,
  input  logic [ADDR_W-1:0] pendAddr,
  input  logic              branchTaken,
  input  logic [ADDR_W-1:0] branchAddr,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jrAddr,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jumpAddr,
  output redirKind_t        winKind,
  output logic [ADDR_W-1:0] winAddr,
  output logic              flushIf,
  output logic              flushId
);

  redirKind_t        liveKind;
  logic [ADDR_W-1:0] liveAddr;

  always_comb begin
    liveKind = KIND_NONE;
    liveAddr = '0;
    if (liveEn) begin
      if (branchTaken) begin
        liveKind = KIND_BR;
        liveAddr = branchAddr;
      end else if (jr) begin
        liveKind = KIND_JR;
        liveAddr = jrAddr;
      end else if (jump) begin
        liveKind = KIND_J;
        liveAddr = jumpAddr;
      end
    end
  end

  always_comb begin
    winKind = pendKind;
    winAddr = pendAddr;
    if (liveKind > pendKind) begin
      winKind = liveKind;
      winAddr = liveAddr;
    end
    // A branch from EX is older than whatever sits in ID, so it kills both stages.
    flushIf = (winKind != KIND_NONE);
    flushId = (winKind == KIND_BR);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: picks branch > jr > jump > sequential, drives the PC-in mux
// select and IF/ID flushes, and parks a redirect seen during a stall until release.
module pc_sequencer
  import pipe_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              jr_i,
  input  logic [ADDR_W-1:0] jr_addr_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic [2:0]        jrjz_o,
  output logic              fetch_valid_o,
  output logic              flush_if_o,
  output logic              flush_id_o,
  output logic              pending_o,
  output logic              misalign_o
);

  seqState_t         state;
  logic [ADDR_W-1:0] pcQ;
  redirKind_t        pendKind;
  logic [ADDR_W-1:0] pendAddr;

  redirKind_t        winKind;
  logic [ADDR_W-1:0] winAddr;
  logic              winFlushIf;
  logic              winFlushId;
  logic              liveEn;
  logic              applyNow;
  logic              redirNow;
  logic [ADDR_W-1:0] seqPc;

  assign liveEn   = (state != BOOT);
  assign applyNow = liveEn && !stall_i;
  assign redirNow = applyNow && (winKind != KIND_NONE);
  assign seqPc    = pcQ + ADDR_W'(4);

  redirect_prio #(.ADDR_W(ADDR_W)) uPrio (
    .liveEn      (liveEn),
    .pendKind    (pendKind),
    .pendAddr    (pendAddr),
    .branchTaken (branch_taken_i),
    .branchAddr  (branch_addr_i),
    .jr          (jr_i),
    .jrAddr      (jr_addr_i),
    .jump        (jump_i),
    .jumpAddr    (jump_addr_i),
    .winKind     (winKind),
    .winAddr     (winAddr),
    .flushIf     (winFlushIf),
    .flushId     (winFlushId)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pcQ      <= RESET_PC;
      pendKind <= KIND_NONE;
      pendAddr <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        default: begin
          if (stall_i) begin
            // Prio already keeps the pending entry on ties, so just re-latch the winner.
            pendKind <= winKind;
            pendAddr <= winAddr;
            state    <= (winKind != KIND_NONE) ? HOLD_PEND : HOLD;
          end else begin
            pcQ      <= (winKind != KIND_NONE) ? {winAddr[ADDR_W-1:2], 2'b00} : seqPc;
            pendKind <= KIND_NONE;
            pendAddr <= '0;
            state    <= RUN;
          end
        end
      endcase
    end
  end

  assign pc_o          = pcQ;
  assign next_pc_o     = seqPc;
  assign jrjz_o        = applyNow ? kindToSel(winKind) : SEL_SEQ;
  assign fetch_valid_o = (state != BOOT);
  assign flush_if_o    = applyNow && winFlushIf;
  assign flush_id_o    = applyNow && winFlushId;
  assign pending_o     = (state == HOLD_PEND);
  assign misalign_o    = redirNow && (winAddr[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, branch_taken_i, jump_i, jr_i;
  logic [31:0] branch_addr_i, jump_addr_i, jr_addr_i;
  logic [31:0] pc_o, next_pc_o;
  logic [2:0]  jrjz_o;
  logic        fetch_valid_o, flush_if_o, flush_id_o, pending_o, misalign_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .branch_taken_i (branch_taken_i),
    .branch_addr_i  (branch_addr_i),
    .jump_i         (jump_i),
    .jump_addr_i    (jump_addr_i),
    .jr_i           (jr_i),
    .jr_addr_i      (jr_addr_i),
    .pc_o           (pc_o),
    .next_pc_o      (next_pc_o),
    .jrjz_o         (jrjz_o),
    .fetch_valid_o  (fetch_valid_o),
    .flush_if_o     (flush_if_o),
    .flush_id_o     (flush_id_o),
    .pending_o      (pending_o),
    .misalign_o     (misalign_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, then let combinational outputs settle.
  task automatic drive(input logic st, input logic br, input logic [31:0] ba,
                       input logic jp, input logic [31:0] ja,
                       input logic r, input logic [31:0] ra);
    stall_i        = st;
    branch_taken_i = br;
    branch_addr_i  = ba;
    jump_i         = jp;
    jump_addr_i    = ja;
    jr_i           = r;
    jr_addr_i      = ra;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chkFlush(input string tag, input logic [2:0] sel, input logic fi, input logic fd);
    chk({tag, "_sel"}, 32'(jrjz_o), 32'(sel));
    chk({tag, "_fif"}, 32'(flush_if_o), 32'(fi));
    chk({tag, "_fid"}, 32'(flush_id_o), 32'(fd));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #10;
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_fv", 32'(fetch_valid_o), 32'h0);
    chk("rst_pend", 32'(pending_o), 32'h0);
    chk("rst_sel", 32'(jrjz_o), 32'h0);
    chk("rst_mis", 32'(misalign_o), 32'h0);

    // BOOT: redirects ignored, fetch not yet valid
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("boot_fv", 32'(fetch_valid_o), 32'h0);
    chkFlush("boot", 3'b000, 1'b0, 1'b0);
    cyc(); idle();
    chk("run0_pc", pc_o, 32'h0);
    chk("run0_fv", 32'(fetch_valid_o), 32'h1);
    chk("run0_npc", next_pc_o, 32'h4);
    cyc();
    chk("run1_pc", pc_o, 32'h4);
    cyc();
    chk("run2_pc", pc_o, 32'h8);

    // Branch beats jump in the same cycle
    drive(1'b0, 1'b1, 32'h80, 1'b1, 32'h40, 1'b0, 32'h0);
    chkFlush("brj", 3'b001, 1'b1, 1'b1);
    chk("brj_mis", 32'(misalign_o), 32'h0);
    cyc(); idle();
    chk("brj_pc", pc_o, 32'h80);

    // Stall: jump latched, then jr replaces it
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
    chkFlush("st1", 3'b000, 1'b0, 1'b0);
    cyc();
    chk("st1_pend", 32'(pending_o), 32'h1);
    chk("st1_pc", pc_o, 32'h80);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h60);
    cyc();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc();
    chk("st3_pend", 32'(pending_o), 32'h1);
    chk("st3_pc", pc_o, 32'h80);
    idle();
    chkFlush("rel_jr", 3'b100, 1'b1, 1'b0);
    cyc();
    chk("rel_jr_pc", pc_o, 32'h60);
    chk("rel_jr_pend", 32'(pending_o), 32'h0);

    // Pending jr is not displaced by a later jump
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h70);
    cyc();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
    cyc(); idle();
    chkFlush("keep_jr", 3'b100, 1'b1, 1'b0);
    cyc();
    chk("keep_jr_pc", pc_o, 32'h70);

    // Pending jr displaced by a later branch
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h60);
    cyc();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
    cyc();
    drive(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(); idle();
    chkFlush("rel_br", 3'b001, 1'b1, 1'b1);
    cyc();
    chk("rel_br_pc", pc_o, 32'h100);

    // Misaligned jump target is aligned and flagged for one cycle
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h43, 1'b0, 32'h0);
    chkFlush("mis", 3'b010, 1'b1, 1'b0);
    chk("mis_pulse", 32'(misalign_o), 32'h1);
    cyc(); idle();
    chk("mis_pc", pc_o, 32'h40);
    chk("mis_clr", 32'(misalign_o), 32'h0);

    // Sequential wrap at the top of the address space
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    cyc(); idle();
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    chk("wrap_npc", next_pc_o, 32'h0);
    cyc();
    chk("wrap_pc2", pc_o, 32'h0);

    // Async reset while holding a pending redirect
    cyc();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
    cyc();
    chk("prst_pend", 32'(pending_o), 32'h1);
    chk("prst_pc", pc_o, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pend", 32'(pending_o), 32'h0);
    chk("arst_pc", pc_o, 32'h0);
    chk("arst_fv", 32'(fetch_valid_o), 32'h0);
    idle();
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("post_pc", pc_o, 32'h4);
    chk("post_pend", 32'(pending_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the fetch program counter and drives the 3-bit select of the PC-in mux in IF.
- Arbitrates redirect requests from EX (taken branch) and ID (jump, jump-register) against stalls from the hazard unit, and generates IF/ID flush pulses.
- Captures a redirect that arrives during a stall and applies it on the first cycle after the stall releases.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall_i  in  1  hazard unit/imem not ready; hold PC.
- branch_taken_i  in  1  taken branch resolved in EX.
- branch_addr_i  in  ADDR_W  branch target.
- jump_i  in  1  J/JAL decoded in ID.
- jump_addr_i  in  ADDR_W  jump target.
- jr_i  in  1  JR decoded in ID.
- jr_addr_i  in  ADDR_W  register target.
- pc_o  out  ADDR_W  current fetch PC.
- next_pc_o  out  ADDR_W  pc_o + 4, feeds mux sequential input.
- jrjz_o  out  3  mux select: 000 seq, 001 branch, 010 jump, 100 jr.
- fetch_valid_o  out  1  instruction at pc_o is valid to fetch.
- flush_if_o  out  1  squash IF/ID register this cycle.
- flush_id_o  out  1  squash ID/EX register this cycle.
- pending_o  out  1  a redirect is latched and waiting.
- misalign_o  out  1  one-cycle pulse: applied target had addr[1:0] != 0.

Behaviour:
- Reset (async, rst_n=0): pc_o=RESET_PC, state=BOOT, pending cleared, jrjz_o=000, fetch_valid_o=0, all flushes=0, misalign_o=0.
- States:
  - BOOT: one cycle, fetch_valid_o=0, then RUN unconditionally. Redirect inputs are ignored in BOOT.
  - RUN: normal operation.
  - HOLD: stalled, nothing pending.
  - HOLD_PEND: stalled, redirect latched.
- Priority, applied every cycle: branch > jr > jump > sequential. The EX branch is the older instruction and also squashes the ID-stage jump/jr.
- RUN, stall_i=0:
  - pc_o <= selected target; the new PC is visible on the next cycle (1-cycle redirect latency).
  - jrjz_o reflects the winner combinationally in the same cycle.
  - Branch win: flush_if_o=1 and flush_id_o=1. Jr/jump win: flush_if_o=1 only.
- RUN, stall_i=1:
  - pc_o holds and jrjz_o=000.
  - If any redirect is asserted, latch winner kind and target, go to HOLD_PEND. Otherwise go to HOLD.
  - No flush is asserted while stalled.
- HOLD/HOLD_PEND, stall_i=1:
  - A new redirect replaces the pending one only if it has strictly higher priority.
  - Equal or lower priority redirects are ignored.
  - HOLD with a redirect goes to HOLD_PEND.
- Release, stall_i=0:
  - Apply max-priority of {pending, live inputs} exactly as in RUN, with the same flushes.
  - Clear pending and go to RUN.
  - HOLD with no live redirect: sequential advance.
- Target alignment: the applied target is loaded with bits[1:0] forced to 00, and misalign_o pulses in the apply cycle.
- Arithmetic: next_pc_o = pc_o + 4, modulo 2^ADDR_W. 32'hFFFF_FFFC wraps to 0; no flag is raised.
- pending_o=1 exactly in HOLD_PEND.
- Reset asserted mid-stall or mid-pending discards the latch immediately.

Decomposition:
- Shared package pipe_pkg:
  - jrjz select constants: SEL_SEQ=3'b000, SEL_BR=3'b001, SEL_J=3'b010, SEL_JR=3'b100.
  - State enum {BOOT, RUN, HOLD, HOLD_PEND}.
  - Redirect-kind priority encoding.
- Sub-module redirect_prio: combinational priority select over pending + live requests; returns kind, target, and flush pair. It is instanced once.
- The existing PC-in mux stays external, driven by jrjz_o.

Test Plan:
1. Reset, then 4 free-running cycles → pc_o = 0, 0 (BOOT, fetch_valid_o=0), 4, 8, 12.
2. At pc=8, assert jump_i and branch_taken_i together (jump_addr=0x40, branch_addr=0x80) → jrjz_o=001, flush_if=flush_id=1, next pc_o=0x80.
3. stall_i high for 3 cycles with jump_i(0x40) in cycle 1 and jr_i(0x60) in cycle 2 → pending_o=1, pc_o held. On release pc_o=0x60 with flush_if=1, flush_id=0.
4. During the stall, pending jr(0x60) then a later jump(0x40) → pending is unchanged. A later branch(0x100) replaces it; release → pc_o=0x100.
5. Jump to 0x43 → pc_o=0x40, misalign_o pulses 1 cycle.
6. pc_o=0xFFFF_FFFC sequential → next pc_o=0. Also: assert rst_n=0 while in HOLD_PEND → pending_o=0 and pc_o=RESET_PC immediately (async).
